// File: rtl/div_unit_if.sv
// Operand/result handshake bundle for div_unit.
// master drives operands and consumes results; slave is the divider itself.
interface div_unit_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic [DIVIDEND_W-1:0] div_in1;
  logic [DIVISOR_W-1:0]  div_in2;
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output div_in1, div_in2, in_valid, out_ready,
    input  in_ready, quotient, remainder, div_by_zero, out_valid
  );

  modport slave (
    input  div_in1, div_in2, in_valid, out_ready,
    output in_ready, quotient, remainder, div_by_zero, out_valid
  );
endinterface

// File: rtl/div_unit.sv
// Restoring unsigned divider, one quotient bit per clock: result DIVIDEND_W edges after accept (next edge for /0).
// Accepts only in IDLE; result held in DONE until out_ready, so a stalled consumer blocks new operands.
module div_unit #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [DIVIDEND_W-1:0] q_sr;
  logic [DIVISOR_W-1:0]  dvsr;
  logic [DIVISOR_W-1:0]  p;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic                  dbz_q;
  logic                  out_valid_q;

  logic [DIVISOR_W:0]    trial;
  logic                  fits;
  logic [DIVISOR_W-1:0]  p_step;
  logic [DIVIDEND_W-1:0] q_step;
  logic                  accept;
  logic                  last_step;
  logic                  divisor_zero;

  // P < divisor always holds, so P is stored in DIVISOR_W bits; only the trial needs the extra bit.
  always_comb begin
    trial  = {p, q_sr[DIVIDEND_W-1]};
    fits   = (trial >= {1'b0, dvsr});
    p_step = fits ? DIVISOR_W'(trial - {1'b0, dvsr}) : trial[DIVISOR_W-1:0];
    q_step = {q_sr[DIVIDEND_W-2:0], fits};
  end

  assign accept       = (state == IDLE) && bus.in_valid;
  assign last_step    = (state == RUN) && (cnt == CNT_W'(1));
  assign divisor_zero = (bus.div_in2 == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = divisor_zero ? DONE : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_sr       <= '0;
      dvsr       <= '0;
      p          <= '0;
      cnt        <= '0;
      quotient_q <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else if (accept) begin
      q_sr <= bus.div_in1;
      dvsr <= bus.div_in2;
      p    <= '0;
      cnt  <= CNT_W'(DIVIDEND_W);
      if (divisor_zero) begin
        quotient_q <= '1;
        rem_q      <= '0;
        dbz_q      <= 1'b1;
      end else begin
        dbz_q <= 1'b0;
      end
    end else if (state == RUN) begin
      q_sr <= q_step;
      p    <= p_step;
      cnt  <= cnt - CNT_W'(1);
      if (last_step) begin
        quotient_q <= q_step;
        rem_q      <= p_step;
      end
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed boundary cases plus a randomized streaming run.
module tb_div_unit;
  localparam int DW = 8;
  localparam int VW = 4;
  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_unit_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus();

  div_unit #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, all-ones quotient for a zero divisor.
  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] a, input logic [VW-1:0] b);
    return (b == 0) ? {DW{1'b1}} : DW'(a / b);
  endfunction

  function automatic logic [VW-1:0] ref_r(input logic [DW-1:0] a, input logic [VW-1:0] b);
    return (b == 0) ? '0 : VW'(a % b);
  endfunction

  task automatic div_once(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b);
    int waitc;
    int lat;
    int exp_lat;
    waitc   = 0;
    lat     = 0;
    exp_lat = (b == 0) ? 0 : DW;
    @(negedge clk);
    while (!bus.in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    bus.div_in1   = a;
    bus.div_in2   = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_q"}, 32'(bus.quotient), 32'(ref_q(a, b)));
    check({tag, "_r"}, 32'(bus.remainder), 32'(ref_r(a, b)));
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(b == 0));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(bus.out_valid), 0);
    check({tag, "_ready_back"}, 32'(bus.in_ready), 1);
  endtask

  logic [DW+VW-1:0] exp_q[$];
  int  sent;
  int  got;
  bit  drv_done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    bus.div_in1   = '0;
    bus.div_in2   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    sent     = 0;
    got      = 0;
    drv_done = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_q", 32'(bus.quotient), 0);
    check("rst_r", 32'(bus.remainder), 0);
    check("rst_dbz", 32'(bus.div_by_zero), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    div_once("basic_200_7", 8'd200, 4'd7);
    div_once("b_255_1", 8'd255, 4'd1);
    div_once("b_5_9", 8'd5, 4'd9);
    div_once("b_0_15", 8'd0, 4'd15);
    div_once("b_225_15", 8'd225, 4'd15);
    div_once("dz_123_0", 8'd123, 4'd0);
    div_once("after_dz_10_3", 8'd10, 4'd3);

    // Backpressure: result held while out_ready is low, new operands ignored
    @(negedge clk);
    bus.div_in1   = 8'd100;
    bus.div_in2   = 4'd6;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wc = 0;
    while (!bus.out_valid && wc < 50) begin
      @(posedge clk);
      #1;
      wc++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_q", 32'(bus.quotient), 16);
      check("bp_r", 32'(bus.remainder), 4);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      bus.div_in1  = DW'($urandom);
      bus.div_in2  = VW'($urandom);
      bus.in_valid = 1'b1;
    end
    // Handoff edge with in_valid still high must not accept
    @(negedge clk);
    bus.div_in1   = 8'd9;
    bus.div_in2   = 4'd2;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 32'(bus.out_valid), 0);
    check("bp_no_accept_on_handoff", 32'(bus.in_ready), 1);
    check("bp_q_kept", 32'(bus.quotient), 16);
    bus.in_valid = 1'b0;

    // Reset during RUN
    @(negedge clk);
    bus.div_in1  = 8'd200;
    bus.div_in2  = 4'd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_q", 32'(bus.quotient), 0);
    check("mid_rst_r", 32'(bus.remainder), 0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    div_once("post_rst_50_4", 8'd50, 4'd4);

    // Randomized streaming with consumer stalls
    fork
      begin
        @(negedge clk);
        for (int i = 0; i < N_RAND; i++) begin
          int gap;
          int w;
          logic [DW-1:0] a;
          logic [VW-1:0] b;
          gap = $urandom_range(0, 2);
          repeat (gap) @(negedge clk);
          a = DW'($urandom);
          b = VW'($urandom_range(0, 15));
          bus.div_in1  = a;
          bus.div_in2  = b;
          bus.in_valid = 1'b1;
          w = 0;
          while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
          end
          if (w >= 200) begin
            check("rand_accept_timeout", 0, 1);
            break;
          end
          exp_q.push_back({a, b});
          sent++;
          @(negedge clk);
          bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        drv_done = 1'b1;
      end
      begin
        int cyc;
        logic [DW+VW-1:0] e;
        logic [DW-1:0] ea;
        logic [VW-1:0] eb;
        cyc = 0;
        while (!(drv_done && got == sent) && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
              check("rand_spurious_result", 0, 1);
            end else begin
              e  = exp_q.pop_front();
              ea = e[DW+VW-1:VW];
              eb = e[VW-1:0];
              check("rand_q", 32'(bus.quotient), 32'(ref_q(ea, eb)));
              check("rand_r", 32'(bus.remainder), 32'(ref_r(ea, eb)));
              check("rand_dbz", 32'(bus.div_by_zero), 32'(eb == 0));
              if (eb != 0) begin
                check("rand_identity", 32'(bus.quotient) * 32'(eb) + 32'(bus.remainder), 32'(ea));
                check("rand_r_lt_d", 32'(bus.remainder < eb), 1);
              end
            end
            got++;
          end
        end
      end
    join
    check("rand_sent", 32'(sent), N_RAND);
    check("rand_results", 32'(got), N_RAND);
    check("rand_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
